wb_ctrl_seq: RTL

- Parametrised, registered successor of the combinational WB-stage decoder.
- Decodes the retiring instruction and drives the register-file write port.
- Owns the stack pointer, OUT port register, sticky halt latch and a multi-cycle interrupt-entry sequencer.
- Sits between the MEM/WB pipeline register and the register file; its stall output freezes upstream stages.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/wb_sp_unit.sv | 33 +++
 rtl/wb_ctrl_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode/sub-op constants and interrupt sequencer state type for the
// write-back stage.
package cpu_pkg;

    // Major opcodes as seen in the WB stage
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_SHF  = 4'd6;
    localparam logic [3:0] OP_STK  = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_INC  = 4'd10;
    localparam logic [3:0] OP_CALL = 4'd11;
    localparam logic [3:0] OP_LDI  = 4'd12;
    localparam logic [3:0] OP_LDD  = 4'd13;
    localparam logic [3:0] OP_STD  = 4'd14;
    localparam logic [3:0] OP_HLT  = 4'd15;

    // Sub-ops of OP_STK (carried in ra[1:0])
    localparam logic [1:0] SUB_PUSH = 2'd0;
    localparam logic [1:0] SUB_POP  = 2'd1;
    localparam logic [1:0] SUB_OUT  = 2'd2;
    localparam logic [1:0] SUB_IN   = 2'd3;

    // Sub-ops of OP_CALL (carried in ra[1:0])
    localparam logic [1:0] SUB_CALL = 2'd1;
    localparam logic [1:0] SUB_RET  = 2'd2;
    localparam logic [1:0] SUB_RTI  = 2'd3;

    // Interrupt-entry sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        ACK  = 2'd2
    } int_state_t;

endpackage

// File: rtl/wb_sp_unit.sv
// Stack pointer register: load beats inc/dec, arithmetic wraps modulo
// 2^DATA_W and a wrap leaves a sticky error flag until reset.
module wb_sp_unit #(
    parameter int              DATA_W   = 8,
    parameter logic [DATA_W-1:0] SP_RESET = 'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] sp,
    output logic              sp_err
);

    // SP update with load priority and wrap detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp     <= SP_RESET;
            sp_err <= 1'b0;
        end else if (load) begin
            sp <= load_data;
        end else if (dec) begin
            sp <= sp - DATA_W'(1);
            if (sp == '0) sp_err <= 1'b1;
        end else if (inc) begin
            sp <= sp + DATA_W'(1);
            if (sp == '1) sp_err <= 1'b1;
        end
    end

endmodule

// File: rtl/wb_ctrl_seq.sv
// Registered WB-stage controller: decodes the retiring instruction into a
// register-file write, owns SP / OUT port / halt latch, and sequences
// interrupt entry (push words, then acknowledge).
module wb_ctrl_seq
    import cpu_pkg::*;
#(
    parameter int                DATA_W         = 8,
    parameter int                REG_CNT        = 4,
    parameter int                SP_IDX         = 3,
    parameter logic [DATA_W-1:0] SP_RESET       = 'hFF,
    parameter int                INT_PUSH_WORDS = 2,
    localparam int               AW             = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [3:0]        opcode,
    input  logic [AW-1:0]     ra_wb,
    input  logic [AW-1:0]     rb_wb,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] in_port,
    input  logic              int_req,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] sp_o,
    output logic              sp_err,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    output logic              halted,
    output logic              int_busy,
    output logic              int_ack,
    output logic              stall
);

    localparam logic [AW-1:0] SP_ADDR = AW'(SP_IDX);
    localparam int            CW      = $clog2(INT_PUSH_WORDS + 1);
    localparam logic [CW-1:0] LAST    = CW'(INT_PUSH_WORDS - 1);

    int_state_t        state;
    logic [CW-1:0]     cnt;

    logic              go;
    logic [1:0]        sub;
    logic              we_d;
    logic [AW-1:0]     waddr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              sp_inc;
    logic              sp_dec;
    logic              sp_load;
    logic              out_we;
    logic              halt_set;

    assign go  = wb_valid && (state == IDLE) && !halted;
    assign sub = ra_wb[1:0];

    // Decode of the retiring instruction plus SP pre-decrement during PUSH
    always_comb begin
        we_d     = 1'b0;
        waddr_d  = '0;
        wdata_d  = '0;
        sp_inc   = 1'b0;
        sp_dec   = 1'b0;
        out_we   = 1'b0;
        halt_set = 1'b0;
        if (go) begin
            case (opcode)
                OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_INC: begin
                    we_d    = 1'b1;
                    waddr_d = ra_wb;
                    wdata_d = wb_data;
                end
                OP_SHF, OP_LDI: begin
                    if (!sub[1]) begin
                        we_d    = 1'b1;
                        waddr_d = rb_wb;
                        wdata_d = wb_data;
                    end
                end
                OP_LDD: begin
                    we_d    = 1'b1;
                    waddr_d = rb_wb;
                    wdata_d = wb_data;
                end
                OP_STK: begin
                    case (sub)
                        SUB_PUSH: sp_dec = 1'b1;
                        SUB_POP: begin
                            we_d    = 1'b1;
                            waddr_d = rb_wb;
                            wdata_d = wb_data;
                            sp_inc  = 1'b1;
                        end
                        SUB_OUT: out_we = 1'b1;
                        default: begin
                            we_d    = 1'b1;
                            waddr_d = rb_wb;
                            wdata_d = in_port;
                        end
                    endcase
                end
                OP_CALL: begin
                    if (sub == SUB_CALL) sp_dec = 1'b1;
                    else if (sub == SUB_RET || sub == SUB_RTI) sp_inc = 1'b1;
                end
                OP_HLT: halt_set = 1'b1;
                default: ;
            endcase
        end
        if (state == PUSH) sp_dec = 1'b1;
    end

    // Writing the SP alias overrides the instruction's own inc/dec
    assign sp_load = we_d && (waddr_d == SP_ADDR);

    wb_sp_unit #(
        .DATA_W   (DATA_W),
        .SP_RESET (SP_RESET)
    ) u_sp (
        .clk       (clk),
        .rst       (rst),
        .inc       (sp_inc && !sp_load),
        .dec       (sp_dec && !sp_load),
        .load      (sp_load),
        .load_data (wdata_d),
        .sp        (sp_o),
        .sp_err    (sp_err)
    );

    // Interrupt FSM, halt latch and all registered stage outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            out_port  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            int_busy  <= 1'b0;
            int_ack   <= 1'b0;
            stall     <= 1'b0;
        end else begin
            rf_we     <= we_d;
            rf_waddr  <= waddr_d;
            rf_wdata  <= wdata_d;
            out_valid <= out_we;
            if (out_we) out_port <= wb_data;
            int_ack   <= 1'b0;
            case (state)
                IDLE: begin
                    if (int_req) begin
                        state    <= PUSH;
                        cnt      <= '0;
                        halted   <= 1'b0;
                        int_busy <= 1'b1;
                        stall    <= 1'b1;
                    end else if (halt_set) begin
                        halted <= 1'b1;
                        stall  <= 1'b1;
                    end
                end
                PUSH: begin
                    if (cnt == LAST) begin
                        state   <= ACK;
                        int_ack <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    int_busy <= 1'b0;
                    stall    <= 1'b0;
                end
            endcase
        end
    end

endmodule
